buf_alloc_ctrl: RTL and testbench

- Tag-lookup and buffer-allocation controller for a 4-entry buffer pool.
- Drives the `lru_finder` from the requesting side: its `ref_buf_numbr` output reports buffer touches, its `new_buf_req` output asks for a replacement, and it consumes `buf_num_replc`.
- On a hit it returns the matching buffer. On a miss it allocates the lowest-index invalid buffer, otherwise the LRU victim, then runs a fill handshake with backing store before acknowledging the requester.

---
 rtl/buf_alloc_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_buf_alloc_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/buf_alloc_ctrl.sv
// Tag-lookup and buffer-allocation controller for a 4-entry pool.
// Hits return the matching buffer; misses fill an invalid slot or the LRU victim reported by lru_finder.
module buf_alloc_ctrl #(
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             acc_req,
   input  logic [TAG_W-1:0] acc_tag,
   input  logic             flush,
   output logic             acc_ack,
   output logic             acc_hit,
   output logic [1:0]       acc_buf,
   output logic             busy,
   output logic             new_buf_req,
   output logic [1:0]       ref_buf_numbr,
   input  logic [1:0]       buf_num_replc,
   output logic             fill_req,
   output logic [1:0]       fill_buf,
   output logic [TAG_W-1:0] fill_tag,
   output logic             evict_vld,
   output logic [TAG_W-1:0] evict_tag,
   input  logic             fill_ack
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOOKUP = 3'd1;
   localparam logic [2:0] S_ALLOC  = 3'd2;
   localparam logic [2:0] S_FILL   = 3'd3;
   localparam logic [2:0] S_RESP   = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [3:0]       valid_q, valid_d;
   logic [TAG_W-1:0] tag_q [4];
   logic             tag_we;
   logic [TAG_W-1:0] req_tag_q, req_tag_d;
   logic [1:0]       ref_q, ref_d;
   logic [1:0]       fill_buf_q, fill_buf_d;
   logic             evict_vld_q, evict_vld_d;
   logic [TAG_W-1:0] evict_tag_q, evict_tag_d;
   logic [1:0]       acc_buf_q, acc_buf_d;
   logic             acc_hit_q, acc_hit_d;

   logic [3:0]       hit_vec;
   logic             any_hit;
   logic [1:0]       hit_idx;
   logic             any_free;
   logic [1:0]       free_idx;

   // Valid entries never share a tag, so hit_vec is one-hot or zero.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_entry
         assign hit_vec[gi] = valid_q[gi] && (tag_q[gi] == req_tag_q);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               tag_q[gi] <= '0;
            end else if (tag_we && (fill_buf_q == 2'(gi))) begin
               tag_q[gi] <= req_tag_q;
            end
         end
      end
   endgenerate

   assign any_hit  = |hit_vec;
   assign any_free = ~&valid_q;

   always_comb begin
      hit_idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (hit_vec[i]) hit_idx = 2'(i);
      end
   end

   // Scan downwards so the lowest invalid index wins.
   always_comb begin
      free_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!valid_q[i]) free_idx = 2'(i);
      end
   end

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      tag_we      = 1'b0;
      req_tag_d   = req_tag_q;
      ref_d       = ref_q;
      fill_buf_d  = fill_buf_q;
      evict_vld_d = evict_vld_q;
      evict_tag_d = evict_tag_q;
      acc_buf_d   = acc_buf_q;
      acc_hit_d   = acc_hit_q;

      case (state_q)
         S_IDLE: begin
            if (flush) begin
               valid_d = 4'b0000;
            end else if (acc_req) begin
               req_tag_d = acc_tag;
               state_d   = S_LOOKUP;
            end
         end

         S_LOOKUP: begin
            if (any_hit) begin
               ref_d     = hit_idx;
               acc_buf_d = hit_idx;
               acc_hit_d = 1'b1;
               state_d   = S_RESP;
            end else if (any_free) begin
               ref_d       = free_idx;
               fill_buf_d  = free_idx;
               evict_vld_d = 1'b0;
               state_d     = S_FILL;
            end else begin
               state_d = S_ALLOC;
            end
         end

         // new_buf_req is high for this single cycle; the finder promotes the victim at this edge.
         S_ALLOC: begin
            ref_d       = buf_num_replc;
            fill_buf_d  = buf_num_replc;
            evict_vld_d = 1'b1;
            evict_tag_d = tag_q[buf_num_replc];
            state_d     = S_FILL;
         end

         S_FILL: begin
            if (fill_ack) begin
               tag_we               = 1'b1;
               valid_d[fill_buf_q]  = 1'b1;
               evict_vld_d          = 1'b0;
               acc_buf_d            = fill_buf_q;
               acc_hit_d            = 1'b0;
               state_d              = S_RESP;
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         valid_q     <= 4'b0000;
         req_tag_q   <= '0;
         ref_q       <= 2'd0;
         fill_buf_q  <= 2'd0;
         evict_vld_q <= 1'b0;
         evict_tag_q <= '0;
         acc_buf_q   <= 2'd0;
         acc_hit_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         req_tag_q   <= req_tag_d;
         ref_q       <= ref_d;
         fill_buf_q  <= fill_buf_d;
         evict_vld_q <= evict_vld_d;
         evict_tag_q <= evict_tag_d;
         acc_buf_q   <= acc_buf_d;
         acc_hit_q   <= acc_hit_d;
      end
   end

   assign acc_ack       = (state_q == S_RESP);
   assign acc_hit       = acc_hit_q && (state_q == S_RESP);
   assign acc_buf       = (state_q == S_RESP) ? acc_buf_q : 2'd0;
   assign busy          = (state_q != S_IDLE);
   assign new_buf_req   = (state_q == S_ALLOC);
   assign ref_buf_numbr = ref_q;
   assign fill_req      = (state_q == S_FILL);
   assign fill_buf      = fill_buf_q;
   assign fill_tag      = req_tag_q;
   assign evict_vld     = evict_vld_q;
   assign evict_tag     = evict_tag_q;

endmodule

// File: tb/tb_buf_alloc_ctrl.sv
// Scoreboard bench for buf_alloc_ctrl with a behavioural LRU finder and a delayed-ack backing store.
module tb_buf_alloc_ctrl;

   localparam int TAG_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             acc_req = 1'b0;
   logic [TAG_W-1:0] acc_tag = '0;
   logic             flush = 1'b0;
   logic             acc_ack;
   logic             acc_hit;
   logic [1:0]       acc_buf;
   logic             busy;
   logic             new_buf_req;
   logic [1:0]       ref_buf_numbr;
   logic [1:0]       buf_num_replc;
   logic             fill_req;
   logic [1:0]       fill_buf;
   logic [TAG_W-1:0] fill_tag;
   logic             evict_vld;
   logic [TAG_W-1:0] evict_tag;
   logic             fill_ack = 1'b0;

   always #5 clk = ~clk;

   buf_alloc_ctrl #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .acc_req(acc_req), .acc_tag(acc_tag), .flush(flush),
      .acc_ack(acc_ack), .acc_hit(acc_hit), .acc_buf(acc_buf), .busy(busy),
      .new_buf_req(new_buf_req), .ref_buf_numbr(ref_buf_numbr), .buf_num_replc(buf_num_replc),
      .fill_req(fill_req), .fill_buf(fill_buf), .fill_tag(fill_tag),
      .evict_vld(evict_vld), .evict_tag(evict_tag), .fill_ack(fill_ack)
   );

   typedef struct packed {logic hit; logic [1:0] bufn;} ack_exp_t;
   typedef struct packed {logic [1:0] bufn; logic [7:0] tag; logic ev; logic [7:0] evtag;} fill_exp_t;

   ack_exp_t  ack_q[$];
   fill_exp_t fill_q[$];
   int checks = 0;
   int failures = 0;
   int fill_delay = 0;
   int alloc_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural LRU finder: lru_ord[0] is least recent, lru_ord[3] most recent.
   logic [1:0] lru_ord [4];
   logic [1:0] m_b;
   logic [1:0] m_nxt [4];
   int         m_j;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) lru_ord[i] <= 2'(i);
      end else begin
         m_b = new_buf_req ? lru_ord[0] : ref_buf_numbr;
         m_j = 0;
         for (int i = 0; i < 4; i++) begin
            if (lru_ord[i] != m_b) begin
               m_nxt[m_j] = lru_ord[i];
               m_j++;
            end
         end
         m_nxt[3] = m_b;
         for (int i = 0; i < 4; i++) lru_ord[i] <= m_nxt[i];
      end
   end
   assign buf_num_replc = lru_ord[0];

   // Backing store: ack fill_delay cycles after fill_req is first seen, for one cycle.
   int fd_cnt = 0;
   initial forever begin
      @(negedge clk);
      if (fill_ack) begin
         fill_ack = 1'b0;
         fd_cnt = 0;
      end else if (fill_req) begin
         if (fd_cnt >= fill_delay) fill_ack = 1'b1;
         else fd_cnt++;
      end else begin
         fd_cnt = 0;
      end
   end

   // Ack monitor.
   logic prev_ack = 1'b0;
   ack_exp_t ae;
   initial forever begin
      @(negedge clk);
      if (acc_ack) begin
         check("ack_one_cycle", 32'(prev_ack), 32'd0);
         if (ack_q.size() == 0) begin
            check("ack_unexpected", 32'(acc_ack), 32'd0);
         end else begin
            ae = ack_q.pop_front();
            check("ack_hit", 32'(acc_hit), 32'(ae.hit));
            check("ack_buf", 32'(acc_buf), 32'(ae.bufn));
         end
      end
      prev_ack = acc_ack;
   end

   // Fill monitor: compares first cycle against expectation, then holds stable.
   logic prev_fill = 1'b0;
   fill_exp_t fe;
   logic [18:0] fill_hold;
   initial forever begin
      @(negedge clk);
      if (fill_req && !prev_fill) begin
         if (fill_q.size() == 0) begin
            check("fill_unexpected", 32'(fill_req), 32'd0);
         end else begin
            fe = fill_q.pop_front();
            check("fill_buf", 32'(fill_buf), 32'(fe.bufn));
            check("fill_tag", 32'(fill_tag), 32'(fe.tag));
            check("evict_vld", 32'(evict_vld), 32'(fe.ev));
            if (fe.ev) check("evict_tag", 32'(evict_tag), 32'(fe.evtag));
         end
         fill_hold = {fill_buf, fill_tag, evict_vld, evict_tag};
      end else if (fill_req) begin
         check("fill_hold", 32'({fill_buf, fill_tag, evict_vld, evict_tag}), 32'(fill_hold));
      end
      prev_fill = fill_req;
   end

   // Replacement request monitor.
   logic prev_nbr = 1'b0;
   initial forever begin
      @(negedge clk);
      if (new_buf_req) begin
         alloc_cnt++;
         check("nbr_consecutive", 32'(prev_nbr), 32'd0);
         check("nbr_with_fill", 32'(fill_req), 32'd0);
      end
      prev_nbr = new_buf_req;
   end

   task automatic access(input logic [7:0] tag, input logic hit, input logic [1:0] bufn,
                         input logic ev, input logic [7:0] evtag, input int alloc_exp,
                         input int lat_exp, input int fdel, input bit flush_in_fill);
      int  cyc;
      int  a0;
      bit  done;
      bit  busy_bad;
      bit  flushed;
      fill_delay = fdel;
      ack_q.push_back('{hit, bufn});
      if (!hit) fill_q.push_back('{bufn, tag, ev, evtag});
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      acc_req = 1'b1;
      acc_tag = tag;
      a0 = alloc_cnt;
      cyc = 0; done = 0; busy_bad = 0; flushed = 0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         acc_tag = ~tag;
         if (!busy) busy_bad = 1;
         if (flush_in_fill && fill_req && !flushed) begin
            flush = 1'b1;
            flushed = 1;
         end else begin
            flush = 1'b0;
         end
         if (acc_ack) done = 1;
      end
      acc_req = 1'b0;
      flush = 1'b0;
      check("ack_latency", 32'(cyc), 32'(lat_exp));
      check("busy_during", 32'(busy_bad), 32'd0);
      check("alloc_count", 32'(alloc_cnt - a0), 32'(alloc_exp));
      check("ref_buf", 32'(ref_buf_numbr), 32'(bufn));
      @(negedge clk);
      check("busy_after", 32'(busy), 32'd0);
   endtask

   initial begin
      int w;
      // Reset state.
      #12;
      check("rst_ack", 32'(acc_ack), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fill_req", 32'(fill_req), 32'd0);
      check("rst_nbr", 32'(new_buf_req), 32'd0);
      check("rst_ref", 32'(ref_buf_numbr), 32'd0);
      check("rst_evict_vld", 32'(evict_vld), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: fill the four invalid slots in order.
      access(8'h10, 0, 2'd0, 0, 8'h00, 0, 3, 0, 0);
      access(8'h20, 0, 2'd1, 0, 8'h00, 0, 3, 0, 0);
      access(8'h30, 0, 2'd2, 0, 8'h00, 0, 3, 0, 0);
      access(8'h40, 0, 2'd3, 0, 8'h00, 0, 3, 0, 0);
      // 2: hit.
      access(8'h20, 1, 2'd1, 0, 8'h00, 0, 2, 0, 0);
      // 3: LRU order 0,2,3,1.
      access(8'h50, 0, 2'd0, 1, 8'h10, 1, 4, 0, 0);
      access(8'h60, 0, 2'd2, 1, 8'h30, 1, 4, 0, 0);
      // 4: delayed fill, order now 3,1,0,2.
      access(8'h70, 0, 2'd3, 1, 8'h40, 1, 9, 5, 0);
      access(8'h50, 1, 2'd0, 0, 8'h00, 0, 2, 0, 0);

      // 5: flush wins over a simultaneous request.
      @(negedge clk);
      flush = 1'b1;
      acc_req = 1'b1;
      acc_tag = 8'h20;
      @(negedge clk);
      check("flush_priority_busy", 32'(busy), 32'd0);
      flush = 1'b0;
      acc_req = 1'b0;
      access(8'h20, 0, 2'd0, 0, 8'h00, 0, 3, 0, 0);
      access(8'h30, 0, 2'd1, 0, 8'h00, 0, 6, 3, 1);
      access(8'h20, 1, 2'd0, 0, 8'h00, 0, 2, 0, 0);
      access(8'h40, 0, 2'd2, 0, 8'h00, 0, 3, 0, 0);
      access(8'h50, 0, 2'd3, 0, 8'h00, 0, 3, 0, 0);

      // 6: LRU order 1,0,2,3; reset while filling over buffer 1.
      fill_delay = 10000;
      fill_q.push_back('{2'd1, 8'h77, 1'b1, 8'h30});
      @(negedge clk);
      acc_req = 1'b1;
      acc_tag = 8'h77;
      w = 0;
      while (!fill_req && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("abort_fill_seen", 32'(fill_req), 32'd1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_fill_req", 32'(fill_req), 32'd0);
      check("async_busy", 32'(busy), 32'd0);
      check("async_evict_vld", 32'(evict_vld), 32'd0);
      check("async_ref", 32'(ref_buf_numbr), 32'd0);
      acc_req = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      access(8'h30, 0, 2'd0, 0, 8'h00, 0, 3, 0, 0);

      repeat (2) @(negedge clk);
      check("ack_queue_empty", 32'(ack_q.size()), 32'd0);
      check("fill_queue_empty", 32'(fill_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
